// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: execute-resolve and instruction-fetch bus of the fetch PC controller.
interface pc_fetch_ctrl_if #(parameter int XLEN = 64);
   logic            stall, branch, jump, jalr;
   logic [2:0]      br_cond;
   logic            zero, lt, ltu;
   logic [XLEN-1:0] pc_ex, imm_ext, rs1_val;
   logic            fetch_ready;
   logic [XLEN-1:0] pc_fetch;
   logic            fetch_valid, redirect;
   logic [XLEN-1:0] link_addr;
   logic            trap;
   logic [XLEN-1:0] trap_pc;
   modport master (
      input  stall, branch, jump, jalr, br_cond, zero, lt, ltu, pc_ex, imm_ext, rs1_val, fetch_ready,
      output pc_fetch, fetch_valid, redirect, link_addr, trap, trap_pc
   );
   modport slave (
      output stall, branch, jump, jalr, br_cond, zero, lt, ltu, pc_ex, imm_ext, rs1_val, fetch_ready,
      input  pc_fetch, fetch_valid, redirect, link_addr, trap, trap_pc
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch PC register with valid/ready fetch handshake and branch/JAL/JALR redirect.
// Define PC_MISALIGN_TRAP_EN to send misaligned taken targets to TRAP_VEC with a trap pulse.
module pc_fetch_ctrl #(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              IMM_SHIFT = 1
`ifdef PC_MISALIGN_TRAP_EN
   ,
   parameter logic [XLEN-1:0] TRAP_VEC  = 'h100
`endif
) (
   input logic             clk,
   input logic             reset_n,
   pc_fetch_ctrl_if.master bus
);
   typedef enum logic {BOOT, RUN} state_e;
   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, trap_pc_q, trap_pc_d, target, xfer_pc;
   logic            redirect_q, redirect_d, trap_q, trap_d;
   logic            cmp, br_taken, taken;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         redirect_q <= 1'b0;
         trap_q     <= 1'b0;
         trap_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         trap_q     <= trap_d;
         trap_pc_q  <= trap_pc_d;
      end
   end
   always_comb state_d = RUN;
   // br_cond[2] selects the lt/ltu flags, [1] picks unsigned, [0] inverts the sense
   always_comb begin
      cmp      = bus.br_cond[2] ? (bus.br_cond[1] ? bus.ltu : bus.lt) : bus.zero;
      br_taken = bus.branch & (bus.br_cond[2] | ~bus.br_cond[1]) & (cmp ^ bus.br_cond[0]);
      taken    = (state_q == RUN) & (bus.jalr | bus.jump | br_taken);
      target   = bus.jalr ? ((bus.rs1_val + bus.imm_ext) & {{(XLEN-1){1'b1}}, 1'b0})
                          : bus.pc_ex + (bus.imm_ext << IMM_SHIFT);
   end
   always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
      trap_d    = taken & (|target[1:0]);
      trap_pc_d = trap_d ? bus.pc_ex : trap_pc_q;
      xfer_pc   = trap_d ? TRAP_VEC : target;
`else
      trap_d    = 1'b0;
      trap_pc_d = '0;
      xfer_pc   = target;
`endif
      redirect_d = taken;
      pc_d       = taken ? xfer_pc
                 : (state_q == RUN && bus.fetch_ready && !bus.stall) ? pc_q + XLEN'(4) : pc_q;
   end
   assign bus.pc_fetch    = pc_q;
   assign bus.fetch_valid = state_q == RUN;
   assign bus.redirect    = redirect_q;
   assign bus.trap        = trap_q;
   assign bus.trap_pc     = trap_pc_q;
   assign bus.link_addr   = bus.pc_ex + XLEN'(4);
endmodule
